// File: rtl/multi_cycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - FSM state encodings (IF .. HALT)
//   - RV32I major opcodes consumed by the sequencer
//   - datapath mux-select / ALU-op encodings
//   - ctrl_t: the control bundle produced by the output decoder
//   - is_retire: tells whether a state transition retires an instruction
// -----------------------------------------------------------------------------
package multi_cycle_control_unit_pkg;

    localparam int STATE_WIDTH = 4;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX     = 4'd2,
        S_WB_ALU = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_MEM = 4'd7,
        S_BR     = 4'd8,
        S_JAL    = 4'd9,
        S_JALR   = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] WD_ALUOUT    = 2'b00;
    localparam logic [1:0] WD_MDR       = 2'b01;
    localparam logic [1:0] WD_PC        = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wd_sel;
        logic       is_halted;
    } ctrl_t;

    // An instruction retires when the FSM moves into IF or HALT from any
    // state other than IF (IF->IF is a fetch stall) or HALT (absorbing).
    function automatic logic is_retire(input state_e cur, input state_e nxt);
        logic to_end;
        logic from_body;
        to_end    = (nxt == S_IF) || (nxt == S_HALT);
        from_body = (cur != S_IF) && (cur != S_HALT);
        return to_end && from_body;
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit_if
// Bundle between the control unit and the multi-cycle datapath/memory.
//   Datapath -> control : opcode, alu_bcond, mem_ready, is_halt_cond
//   Control -> datapath : memory request, IR/PC enables, mux selects, ALU op,
//                         register write, halt flag, retired-instruction count
// modport master : the control unit (drives the control signals)
// modport slave  : the datapath side
// -----------------------------------------------------------------------------
interface multi_cycle_control_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [6:0]           opcode;
    logic                 alu_bcond;
    logic                 mem_ready;
    logic                 is_halt_cond;

    logic                 mem_read;
    logic                 mem_write;
    logic                 i_or_d;
    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic [1:0]           pc_source;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic                 reg_write;
    logic [1:0]           wd_sel;
    logic                 is_halted;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  opcode, alu_bcond, mem_ready, is_halt_cond,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, reg_write, wd_sel,
               is_halted, instret
    );

    modport slave (
        output opcode, alu_bcond, mem_ready, is_halt_cond,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, reg_write, wd_sel,
               is_halted, instret
    );
endinterface

// File: rtl/multi_cycle_control_unit_control_output_decoder.sv
// -----------------------------------------------------------------------------
// control_output_decoder
// Purely combinational: current FSM state (+ mem_ready, opcode) -> control bundle.
//   state_i     : current FSM state
//   mem_ready_i : memory handshake; gates ir_write/pc_write in IF
//   opcode_i    : selects ALU operand B in EX (register vs immediate form)
//   ctrl_o      : every datapath enable and mux select
// -----------------------------------------------------------------------------
module control_output_decoder
    import multi_cycle_control_unit_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o
);

    // State -> control bundle; anything not set for a state stays 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_IF: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = SRC_A_PC;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.pc_source = PC_SRC_ALU;
                // IR and PC only capture in the cycle the fetch completes
                if (mem_ready_i) begin
                    ctrl_o.ir_write = 1'b1;
                    ctrl_o.pc_write = 1'b1;
                end else begin
                    ctrl_o.ir_write = 1'b0;
                    ctrl_o.pc_write = 1'b0;
                end
            end
            S_ID: begin
                // Speculative branch/jump target: ALUOut <= old_pc + imm
                ctrl_o.alu_src_a = SRC_A_OLD_PC;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_EX: begin
                ctrl_o.alu_src_a = SRC_A_RS1;
                if (opcode_i == OP_ARITH_IMM) begin
                    ctrl_o.alu_src_b = SRC_B_IMM;
                end else begin
                    ctrl_o.alu_src_b = SRC_B_RS2;
                end
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            S_WB_ALU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wd_sel    = WD_ALUOUT;
            end
            S_ADDR: begin
                ctrl_o.alu_src_a = SRC_A_RS1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wd_sel    = WD_MDR;
            end
            S_BR: begin
                // ALU compares rs1/rs2; datapath writes PC from ALUOut iff taken
                ctrl_o.alu_src_a     = SRC_A_RS1;
                ctrl_o.alu_src_b     = SRC_B_RS2;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PC_SRC_ALUOUT;
            end
            S_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wd_sel    = WD_PC;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PC_SRC_ALUOUT;
            end
            S_JALR: begin
                ctrl_o.alu_src_a = SRC_A_RS1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wd_sel    = WD_PC;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PC_SRC_JALR;
            end
            S_HALT: begin
                ctrl_o.is_halted = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit
// Sequencer for the shared multi-cycle RV32I datapath.
//   clk   : single clock, all state on posedge
//   reset : synchronous, active-high; forces every output to 0 while high
//   bus   : multi_cycle_control_unit_if.master (decoded opcode, branch
//           condition, memory handshake in; all enables/selects and the
//           retired-instruction counter out)
// State register, next-state logic and instret live here; the per-state
// control bundle comes from control_output_decoder.
// -----------------------------------------------------------------------------
module multi_cycle_control_unit
    import multi_cycle_control_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    multi_cycle_control_unit_if.master  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] instret_q;
    logic [CNT_WIDTH-1:0] instret_d;
    ctrl_t                ctrl_s;

    control_output_decoder u_decoder (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .opcode_i    (bus.opcode),
        .ctrl_o      (ctrl_s)
    );

    // Next-state selection; mem_ready only matters in the three memory states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (bus.mem_ready) begin
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                case (bus.opcode)
                    OP_ARITH, OP_ARITH_IMM: state_d = S_EX;
                    OP_LOAD, OP_STORE:      state_d = S_ADDR;
                    OP_BRANCH:              state_d = S_BR;
                    OP_JAL:                 state_d = S_JAL;
                    OP_JALR:                state_d = S_JALR;
                    OP_ECALL: begin
                        if (bus.is_halt_cond) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_IF;
                        end
                    end
                    // Unknown opcodes retire as a NOP
                    default:                state_d = S_IF;
                endcase
            end
            S_EX:     state_d = S_WB_ALU;
            S_WB_ALU: state_d = S_IF;
            S_ADDR: begin
                if (bus.opcode == OP_LOAD) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    state_d = S_WB_MEM;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_WB_MEM: state_d = S_IF;
            S_BR:     state_d = S_IF;
            S_JAL:    state_d = S_IF;
            S_JALR:   state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    // Retire counter advances on the transition that completes an instruction
    always_comb begin
        if (is_retire(state_q, state_d)) begin
            instret_d = instret_q + CNT_ONE;
        end else begin
            instret_d = instret_q;
        end
    end

    // State and counter registers; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Drive the interface; everything reads 0 while reset is asserted
    always_comb begin
        if (reset) begin
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.i_or_d        = 1'b0;
            bus.ir_write      = 1'b0;
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.pc_source     = 2'b00;
            bus.alu_src_a     = 2'b00;
            bus.alu_src_b     = 2'b00;
            bus.alu_op        = 2'b00;
            bus.reg_write     = 1'b0;
            bus.wd_sel        = 2'b00;
            bus.is_halted     = 1'b0;
            bus.instret       = '0;
        end else begin
            bus.mem_read      = ctrl_s.mem_read;
            bus.mem_write     = ctrl_s.mem_write;
            bus.i_or_d        = ctrl_s.i_or_d;
            bus.ir_write      = ctrl_s.ir_write;
            bus.pc_write      = ctrl_s.pc_write;
            bus.pc_write_cond = ctrl_s.pc_write_cond;
            bus.pc_source     = ctrl_s.pc_source;
            bus.alu_src_a     = ctrl_s.alu_src_a;
            bus.alu_src_b     = ctrl_s.alu_src_b;
            bus.alu_op        = ctrl_s.alu_op;
            bus.reg_write     = ctrl_s.reg_write;
            bus.wd_sel        = ctrl_s.wd_sel;
            bus.is_halted     = ctrl_s.is_halted;
            bus.instret       = instret_q;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control_unit
// Scoreboard bench. The stimulus side walks each instruction through the
// phases its class requires (fetch with memory waits, decode, execute steps),
// drives inputs for one cycle at a time and pushes the control word and
// retire count that cycle must show. A monitor pops one entry per cycle on
// the falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_multi_cycle_control_unit;
    import multi_cycle_control_unit_pkg::*;

    localparam int CW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_cycle_control_unit_if #(.CNT_WIDTH(CW)) bus ();

    multi_cycle_control_unit #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [17:0]   ctrl;
        logic [CW-1:0] cnt;
        logic [63:0]   tag;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] instret_m;
    int            abort_k;
    int            cyc_idx;
    bit            aborted;

    logic [17:0] act_s;
    assign act_s = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                    bus.pc_write, bus.pc_write_cond, bus.pc_source,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.reg_write, bus.wd_sel, bus.is_halted};

    // Control word in the same field order as act_s
    function automatic logic [17:0] cw(input logic mr, input logic mw, input logic iod,
                                       input logic irw, input logic pcw, input logic pcc,
                                       input logic [1:0] pcs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic rw, input logic [1:0] wd, input logic h);
        return {mr, mw, iod, irw, pcw, pcc, pcs, a, b, op, rw, wd, h};
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one expected entry per cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act_s !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl[%s] t=%0t actual=%b required=%b", e.tag, $time, act_s, e.ctrl);
            end
            checks++;
            if (bus.instret !== e.cnt) begin
                errors++;
                $display("FAIL instret[%s] t=%0t actual=%0d required=%0d", e.tag, $time, bus.instret, e.cnt);
            end
        end
    end

    // One cycle of stimulus; replaced by a reset cycle at index abort_k
    task automatic emit(input logic rdy, input logic [6:0] opc, input logic hc,
                        input logic [17:0] w, input logic [63:0] tag);
        exp_t e;
        if (aborted) return;
        if (cyc_idx == abort_k) begin
            reset         = 1'b1;
            bus.mem_ready = 1'b0;
            instret_m     = '0;
            e.ctrl        = '0;
            e.cnt         = '0;
            e.tag         = "ABORT";
            aborted       = 1'b1;
        end else begin
            reset         = 1'b0;
            bus.mem_ready = rdy;
            e.ctrl        = w;
            e.cnt         = instret_m;
            e.tag         = tag;
        end
        bus.opcode       = opc;
        bus.is_halt_cond = hc;
        bus.alu_bcond    = rnd1();
        sb_q.push_back(e);
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            reset            = 1'b1;
            bus.mem_ready    = rnd1();
            bus.opcode       = rnd7();
            bus.is_halt_cond = rnd1();
            bus.alu_bcond    = rnd1();
            instret_m        = '0;
            e.ctrl           = '0;
            e.cnt            = '0;
            e.tag            = "RESET";
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model for one instruction: phase sequence by class
    task automatic run_instr(input logic [6:0] opc, input logic hc, input int wif,
                             input int wmem, input int abort);
        logic [17:0] w_fetch;
        logic [17:0] w_ld;
        abort_k = abort;
        cyc_idx = 0;
        aborted = 1'b0;
        w_fetch = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < wif; i++) emit(1'b0, rnd7(), rnd1(), w_fetch, "IF_WAIT");
        emit(1'b1, rnd7(), rnd1(),
             cw(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0), "IF");
        emit(rnd1(), opc, hc,
             cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0), "ID");
        case (opc)
            OP_ARITH, OP_ARITH_IMM: begin
                emit(rnd1(), opc, rnd1(),
                     cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2,
                        (opc == OP_ARITH_IMM) ? 2'd2 : 2'd0, 2'd2, 1'b0, 2'd0, 1'b0), "EX");
                emit(rnd1(), opc, rnd1(),
                     cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0), "WB_ALU");
            end
            OP_LOAD, OP_STORE: begin
                emit(rnd1(), opc, rnd1(),
                     cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0), "ADDR");
                w_ld = (opc == OP_LOAD) ?
                    cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0) :
                    cw(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
                for (int i = 0; i < wmem; i++) emit(1'b0, opc, rnd1(), w_ld, "MEM_WAIT");
                emit(1'b1, opc, rnd1(), w_ld, "MEM");
                if (opc == OP_LOAD) begin
                    emit(rnd1(), opc, rnd1(),
                         cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0), "WB_MEM");
                end
            end
            OP_BRANCH: emit(rnd1(), opc, rnd1(),
                            cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0), "BR");
            OP_JAL:    emit(rnd1(), opc, rnd1(),
                            cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0), "JAL");
            OP_JALR:   emit(rnd1(), opc, rnd1(),
                            cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 2'd2, 2'd0, 1'b1, 2'd2, 1'b0), "JALR");
            default: begin
                // ECALL and unknown opcodes end after decode
            end
        endcase
        if (!aborted) instret_m = instret_m + 32'd1;
    endtask

    task automatic halt_idle(input int n);
        abort_k = -1;
        cyc_idx = 0;
        aborted = 1'b0;
        for (int i = 0; i < n; i++)
            emit(rnd1(), rnd7(), rnd1(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1), "HALT");
    endtask

    logic [6:0] op_tab [8];
    logic [6:0] opc_r;

    initial begin
        op_tab[0] = OP_LOAD;   op_tab[1] = OP_STORE;  op_tab[2] = OP_ARITH;
        op_tab[3] = OP_ARITH_IMM; op_tab[4] = OP_BRANCH; op_tab[5] = OP_JAL;
        op_tab[6] = OP_JALR;   op_tab[7] = OP_ECALL;
        instret_m        = '0;
        reset            = 1'b1;
        bus.opcode       = 7'd0;
        bus.alu_bcond    = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.is_halt_cond = 1'b0;
        @(posedge clk);
        #1;

        do_reset(2);
        run_instr(OP_ARITH, 1'b0, 0, 0, -1);         // R-type, 4 cycles
        run_instr(OP_LOAD, 1'b0, 3, 2, -1);          // 10 cycles with waits
        run_instr(OP_BRANCH, 1'b0, 0, 0, -1);
        run_instr(OP_BRANCH, 1'b0, 0, 0, -1);
        run_instr(7'b0000000, 1'b1, 0, 0, -1);       // unknown opcode -> NOP
        run_instr(OP_ECALL, 1'b0, 0, 0, -1);         // ECALL retires as NOP
        run_instr(OP_ARITH_IMM, 1'b0, 1, 0, -1);
        run_instr(OP_STORE, 1'b0, 0, 1, -1);
        run_instr(OP_JAL, 1'b0, 0, 0, -1);
        run_instr(OP_JALR, 1'b0, 2, 0, -1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) opc_r = rnd7();
            else opc_r = op_tab[$urandom_range(0, 7)];
            run_instr(opc_r, (opc_r == OP_ECALL) ? 1'b0 : rnd1(),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        run_instr(OP_STORE, 1'b0, 0, 3, 4);          // reset mid MEM_WR, mem_ready low
        run_instr(OP_ARITH, 1'b0, 0, 0, -1);
        run_instr(OP_LOAD, 1'b0, 0, 0, -1);
        run_instr(OP_ARITH, 1'b0, 0, 0, 3);          // reset in WB_ALU beats retire
        run_instr(OP_JAL, 1'b0, 0, 0, -1);

        run_instr(OP_ECALL, 1'b1, 1, 0, -1);         // terminating ECALL
        halt_idle(20);
        do_reset(1);
        run_instr(OP_BRANCH, 1'b0, 0, 0, -1);
        run_instr(OP_ARITH, 1'b0, 0, 0, -1);

        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
